// File: rtl/vref_cal_ctrl.sv
// -----------------------------------------------------------------------------
// vref_cal_ctrl
//   Calibration controller for the vREF macro. Drives the CAL bus and closes
//   the loop through an analog comparator (cmp_i = 1 when VOUT is above the
//   target). A successive-approximation search, MSB first, finds the largest
//   CAL code whose VOUT does not exceed the target. In IDLE, software may
//   override the code directly.
//
// Parameters
//   WIDTH          CAL bus width
//   SETTLE_CYCLES  clk cycles waited after each trial code (>= 2)
//   RESET_CODE     code driven out of reset (mid-scale by default)
//
// Ports
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   start_i      in   level, sampled in IDLE: begin calibration
//   abort_i      in   cancel a running calibration, restore last-valid code
//   cal_wr_i     in   software override strobe (IDLE only)
//   cal_wdata_i  in   software override code
//   cmp_i        in   asynchronous comparator output (1 = VOUT above target)
//   cal_o        out  code driven to the vREF CAL pins
//   busy_o       out  calibration in progress (TRIAL/SETTLE/DECIDE)
//   done_o       out  one-cycle pulse, cal_o holds the search result
//   sat_o        out  result is all-zeros or all-ones, held until next start
// -----------------------------------------------------------------------------
module vref_cal_ctrl #(
  parameter int unsigned            WIDTH         = 5,
  parameter int unsigned            SETTLE_CYCLES = 16,
  parameter logic [WIDTH-1:0]       RESET_CODE    = WIDTH'(2 ** (WIDTH - 1))
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cal_wr_i,
  input  logic [WIDTH-1:0] cal_wdata_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] cal_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sat_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (SETTLE_CYCLES < 2) begin : g_settle_chk
    $error("vref_cal_ctrl: SETTLE_CYCLES must be at least 2");
  end

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRIAL  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_cal;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_work;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;
  logic             r_sync1;
  logic             r_sync2;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_decided;
  logic             w_sat_code;
  logic             w_running;

  // r_work only ever holds bits already decided as 1; the bit under test is
  // OR-ed in for the trial and kept only if VOUT stayed at or below target.
  assign w_mask     = WIDTH'(1) << r_bit;
  assign w_trial    = r_work | w_mask;
  assign w_decided  = r_sync2 ? r_work : w_trial;
  assign w_sat_code = (w_decided == '0) || (w_decided == '1);
  assign w_running  = (r_state == ST_TRIAL) || (r_state == ST_SETTLE) ||
                      (r_state == ST_DECIDE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cal   <= RESET_CODE;
      r_last  <= RESET_CODE;
      r_work  <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= cmp_i;
      r_sync2 <= r_sync1;

      if (abort_i && w_running) begin
        r_state <= ST_IDLE;
        r_cal   <= r_last;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_work  <= '0;
              r_bit   <= BW'(WIDTH - 1);
              r_sat   <= 1'b0;
              r_state <= ST_TRIAL;
            end else if (cal_wr_i) begin
              r_cal  <= cal_wdata_i;
              r_last <= cal_wdata_i;
            end
          end

          ST_TRIAL: begin
            r_cal   <= w_trial;
            r_cnt   <= CW'(SETTLE_CYCLES);
            r_state <= ST_SETTLE;
          end

          ST_SETTLE: begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= ST_DECIDE;
            end
          end

          ST_DECIDE: begin
            r_work <= w_decided;
            if (r_bit == '0) begin
              // Result committed on this edge so cal_o already carries the
              // final code during the DONE cycle, while done_o is high.
              r_cal   <= w_decided;
              r_last  <= w_decided;
              r_sat   <= w_sat_code;
              r_state <= ST_DONE;
            end else begin
              r_bit   <= r_bit - BW'(1);
              r_state <= ST_TRIAL;
            end
          end

          ST_DONE: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cal_o  = r_cal;
  assign busy_o = w_running;
  assign done_o = (r_state == ST_DONE);
  assign sat_o  = r_sat;

endmodule

// File: tb/tb_vref_cal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vref_cal_ctrl
//   Scoreboard bench for vref_cal_ctrl with a behavioural vREF model
//   (VOUT = 672 + 8*CAL mV, comparator = VOUT > target). Each expected
//   calibration result is computed from the target as the largest code whose
//   VOUT does not exceed it, pushed into a queue, and popped by a monitor on
//   every done_o pulse.
// -----------------------------------------------------------------------------
module tb_vref_cal_ctrl;

  localparam int W   = 5;
  localparam int S   = 4;
  localparam int LAT = W * (S + 2);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cal_wr = 1'b0;
  logic [W-1:0] cal_wdata = '0;
  logic         cmp;
  logic [W-1:0] cal_o;
  logic         busy_o;
  logic         done_o;
  logic         sat_o;

  int tgt = 0;
  logic glitch_en = 1'b0;
  logic glitch_val = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int m_last = 16;
  int m_sat = 0;

  typedef struct {
    int code;
    int sat;
    int c0;
  } exp_t;

  exp_t sb[$];

  assign cmp = glitch_en ? glitch_val : ((672 + 8 * int'(cal_o)) > tgt);

  vref_cal_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .cal_wr_i    (cal_wr),
    .cal_wdata_i (cal_wdata),
    .cmp_i       (cmp),
    .cal_o       (cal_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_o       (sat_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Largest code whose VOUT stays at or below the target; 0 if none does.
  function automatic int exp_code(int target);
    int best = 0;
    for (int c = 0; c < (1 << W); c++)
      if (672 + 8 * c <= target) best = c;
    return best;
  endfunction

  // Monitor: pops one expectation per done_o pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", int'(done_o), 0);
      end else begin
        e = sb.pop_front();
        chk("done_code", int'(cal_o), e.code);
        chk("done_sat", int'(sat_o), e.sat);
        chk("done_latency", cyc - e.c0, LAT);
        chk("done_busy", int'(busy_o), 0);
      end
    end
  end

  task automatic glitch_burst();
    glitch_en = 1'b1;
    repeat (4) begin
      #1 glitch_val = 1'($urandom);
    end
    // Wrong value held across the next edge, released well before the edge
    // whose sample feeds the decision.
    #3 glitch_val = !((672 + 8 * int'(cal_o)) > tgt);
    #6 glitch_en = 1'b0;
  endtask

  task automatic run_cal(input int target, input bit exp_done, input int glitch_k,
                         input int abort_rel, input int rst_rel, input int wr_rel,
                         input int wr_data, input bit wr_with_start);
    int ec;
    int c0;
    tgt = target;
    @(posedge clk);
    #1 start = 1'b1;
    if (wr_with_start) begin
      cal_wr = 1'b1;
      cal_wdata = W'(wr_data);
    end
    @(posedge clk);
    #1 c0 = cyc;
    start = 1'b0;
    cal_wr = 1'b0;
    m_sat = 0;
    if (exp_done) begin
      ec = exp_code(target);
      m_last = ec;
      m_sat = (ec == 0 || ec == (1 << W) - 1) ? 1 : 0;
      sb.push_back('{code: ec, sat: m_sat, c0: c0});
    end
    for (int r = 0; r <= LAT + 2; r++) begin
      if (r > 0) begin
        @(posedge clk);
        #1;
      end
      abort = (r + 1 == abort_rel);
      rst = (r + 1 == rst_rel);
      cal_wr = (r + 1 == wr_rel);
      if (r + 1 == wr_rel) cal_wdata = W'(wr_data);
      if (r == 6 * glitch_k + 2) begin
        fork
          glitch_burst();
        join_none
      end
      @(negedge clk);
      if (r == 2 && (rst_rel == 0 || rst_rel > 2)) begin
        chk("run_busy", int'(busy_o), 1);
        chk("run_sat_cleared", int'(sat_o), 0);
      end
      if (abort_rel > 0 && r == abort_rel) begin
        chk("abort_cal", int'(cal_o), m_last);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_done", int'(done_o), 0);
      end
      if (rst_rel > 0 && r == rst_rel) begin
        m_last = 16;
        m_sat = 0;
        chk("midrst_cal", int'(cal_o), 16);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_sat", int'(sat_o), 0);
      end
    end
    if (exp_done) chk("done_seen", sb.size(), 0);
    chk("idle_hold_cal", int'(cal_o), m_last);
    chk("idle_hold_sat", int'(sat_o), m_sat);
    chk("idle_busy", int'(busy_o), 0);
  endtask

  task automatic idle_write(input int data);
    @(posedge clk);
    #1 cal_wr = 1'b1;
    cal_wdata = W'(data);
    @(posedge clk);
    #1 cal_wr = 1'b0;
    m_last = data;
    @(negedge clk);
    chk("idle_write", int'(cal_o), data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cal", int'(cal_o), 16);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_sat", int'(sat_o), 0);
    #1 rst = 1'b0;

    run_cal(760, 1, -1, 0, 0, 0, 0, 0);
    run_cal(650, 1, -1, 0, 0, 0, 0, 0);
    run_cal(1000, 1, -1, 0, 0, 0, 0, 0);
    run_cal(900, 1, -1, 0, 0, 0, 0, 0);

    // Calibrate to 11, then abort a restart during the bit-2 settle window.
    run_cal(760, 1, -1, 0, 0, 0, 0, 0);
    run_cal(900, 0, -1, 15, 0, 0, 0, 0);

    idle_write(7);
    // Start and write together: the write is dropped, so abort restores 7.
    run_cal(900, 0, -1, 15, 0, 0, 5, 1);
    // Write while busy is ignored.
    run_cal(760, 1, -1, 0, 0, 10, 3, 0);

    run_cal(900, 1, 1, 0, 0, 0, 0, 0);
    run_cal(760, 1, 3, 0, 0, 0, 0, 0);

    run_cal(650, 1, -1, 0, 0, 0, 0, 0);
    run_cal(900, 0, -1, 0, 15, 0, 0, 0);
    idle_write(9);

    for (int i = 0; i < 12; i++) begin
      int t;
      int g;
      t = int'($urandom_range(1100, 600));
      g = int'($urandom_range(5, 0));
      if (g == 5) g = -1;
      run_cal(t, 1, g, 0, 0, 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    chk("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
